div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched_pkg.sv | 18 +
 rtl/seq_sdiv.sv | 96 +++++++++
 rtl/div_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types for the div_sched block: FSM state encoding and divider latency helper.
// Optional feature macro used by this slice: DIV_SCHED_DZ_FLAG_EN (adds the dz output).
package div_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV_AB = 3'd1,
        CHECK  = 3'd2,
        DIV_CD = 3'd3,
        DONE   = 3'd4
    } state_t;

    // go-to-done latency of seq_sdiv: sign prep, one iteration per bit, sign fixup
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/seq_sdiv.sv
// Sequential signed restoring divider: quotient truncates toward zero, remainder follows dividend.
// Divide-by-zero gives quot=-1, rem=dividend; MIN/-1 gives quot=MIN, rem=0.
module seq_sdiv #(
    parameter int DATAWIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic signed [DATAWIDTH-1:0] dividend,
    input  logic signed [DATAWIDTH-1:0] divisor,
    output logic                        busy,
    output logic                        done,
    output logic signed [DATAWIDTH-1:0] quot,
    output logic signed [DATAWIDTH-1:0] rem
);

    localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_RUN  = 2'd1;
    localparam logic [1:0] PH_FIX  = 2'd2;

    logic [1:0]           phase;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] shq;
    logic [DATAWIDTH-1:0] ub;
    logic [DATAWIDTH-1:0] racc;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz;
    logic [DATAWIDTH:0]   r_sh;
    logic [DATAWIDTH:0]   r_sub;
    logic                 take;

    // magnitude as unsigned so that MIN maps onto 2^(W-1) without overflow
    function automatic logic [DATAWIDTH-1:0] mag(input logic [DATAWIDTH-1:0] x);
        return x[DATAWIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        r_sh  = {racc, shq[DATAWIDTH-1]};
        take  = (r_sh >= {1'b0, ub});
        r_sub = r_sh - {1'b0, ub};
    end

    assign busy = (phase != PH_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            shq   <= '0;
            ub    <= '0;
            racc  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            done  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (go) begin
                        shq   <= mag(dividend);
                        ub    <= mag(divisor);
                        racc  <= '0;
                        neg_q <= dividend[DATAWIDTH-1] ^ divisor[DATAWIDTH-1];
                        neg_r <= dividend[DATAWIDTH-1];
                        dz    <= (divisor == '0);
                        cnt   <= '0;
                        phase <= PH_RUN;
                    end
                end
                PH_RUN: begin
                    shq  <= {shq[DATAWIDTH-2:0], take};
                    racc <= take ? r_sub[DATAWIDTH-1:0] : r_sh[DATAWIDTH-1:0];
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        phase <= PH_FIX;
                    end
                end
                PH_FIX: begin
                    quot  <= dz ? '1 : (neg_q ? (~shq + 1'b1) : shq);
                    rem   <= neg_r ? (~racc + 1'b1) : racc;
                    done  <= 1'b1;
                    phase <= PH_IDLE;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/div_sched.sv
// Computes z = c/d when (a mod b) == zero, else a/b, sharing one seq_sdiv.
// start is sampled only while idle; done pulses one cycle with z valid. Macro DIV_SCHED_DZ_FLAG_EN adds dz.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    input  logic signed [DATAWIDTH-1:0] d,
    input  logic signed [DATAWIDTH-1:0] zero,
    output logic                        busy,
    output logic                        done,
    output logic signed [DATAWIDTH-1:0] z
`ifdef DIV_SCHED_DZ_FLAG_EN
    ,
    output logic                        dz
`endif
);

    state_t                      state;
    logic                        go;
    logic signed [DATAWIDTH-1:0] dvd;
    logic signed [DATAWIDTH-1:0] dvs;
    logic signed [DATAWIDTH-1:0] rc;
    logic signed [DATAWIDTH-1:0] rd;
    logic signed [DATAWIDTH-1:0] rzero;
    logic signed [DATAWIDTH-1:0] q_ab;
    logic signed [DATAWIDTH-1:0] r_ab;
    logic                        div_busy;
    logic                        div_done;
    logic signed [DATAWIDTH-1:0] div_quot;
    logic signed [DATAWIDTH-1:0] div_rem;
`ifdef DIV_SCHED_DZ_FLAG_EN
    logic                        dz_ab;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    seq_sdiv #(.DATAWIDTH(DATAWIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .dividend (dvd),
        .divisor  (dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // dvd/dvs hold a/b for the first division and are reloaded with c/d for the second
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            go    <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            rc    <= '0;
            rd    <= '0;
            rzero <= '0;
            q_ab  <= '0;
            r_ab  <= '0;
            z     <= '0;
`ifdef DIV_SCHED_DZ_FLAG_EN
            dz    <= 1'b0;
            dz_ab <= 1'b0;
`endif
        end else begin
            go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !div_busy) begin
                        dvd   <= a;
                        dvs   <= b;
                        rc    <= c;
                        rd    <= d;
                        rzero <= zero;
                        go    <= 1'b1;
                        state <= DIV_AB;
                    end
                end
                DIV_AB: begin
                    if (div_done) begin
                        q_ab  <= div_quot;
                        r_ab  <= div_rem;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_ab == rzero) begin
                        dvd   <= rc;
                        dvs   <= rd;
                        go    <= 1'b1;
                        state <= DIV_CD;
`ifdef DIV_SCHED_DZ_FLAG_EN
                        dz_ab <= (dvs == '0);
`endif
                    end else begin
                        z     <= q_ab;
                        state <= DONE;
`ifdef DIV_SCHED_DZ_FLAG_EN
                        dz    <= (dvs == '0);
`endif
                    end
                end
                DIV_CD: begin
                    if (div_done) begin
                        z     <= div_quot;
                        state <= DONE;
`ifdef DIV_SCHED_DZ_FLAG_EN
                        dz    <= dz_ab || (dvs == '0);
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
